// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr - N-way memory-port arbiter with lock, watchdog and status
//
// Several requesters (cores, DMA) share one memory port. Each transaction is
// granted round-robin (PRIO=0) or fixed-priority, lowest index first (PRIO=1).
// The winner's address, write data and write flag are captured, so the memory
// side sees stable values for the whole transaction.
//
// Extra features:
//   - lock_a: the current owner keeps the grant for its next request.
//   - Watchdog: after TIMEOUT BUSY cycles the transaction is dropped and
//     rdy_a/err_a pulse together. TIMEOUT=0 disables the watchdog.
//   - busy / grant_id status.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   addr_a, dout_a   per-requester address / write data, slice i at [i*W +: W]
//   din_a            read data, din_m broadcast to every slice
//   req_a, wr_a      per-requester request (held until rdy_a) / write flag
//   lock_a           keep the grant for the requester's next transaction
//   rdy_a, err_a     one-hot completion strobe / timeout strobe
//   addr_m, dout_m   captured address / write data towards memory
//   wr_m, req_m      captured write flag / memory request (high in BUSY)
//   din_m, rdy_m     memory read data / completion
//   busy, grant_id   BUSY status / current or last granted requester
// -----------------------------------------------------------------------------
module mem_arb_rr #(
    parameter int NREQ    = 4,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int PRIO    = 0,
    parameter int TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ*AW-1:0]         addr_a,
    input  logic [NREQ*DW-1:0]         dout_a,
    output logic [NREQ*DW-1:0]         din_a,
    input  logic [NREQ-1:0]            req_a,
    input  logic [NREQ-1:0]            wr_a,
    input  logic [NREQ-1:0]            lock_a,
    output logic [NREQ-1:0]            rdy_a,
    output logic [NREQ-1:0]            err_a,
    output logic [AW-1:0]              addr_m,
    output logic [DW-1:0]              dout_m,
    input  logic [DW-1:0]              din_m,
    output logic                       req_m,
    output logic                       wr_m,
    input  logic                       rdy_m,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    grant_id
);

    localparam int IW  = $clog2(NREQ);
    // Index arithmetic gets one spare bit so last+k cannot overflow before
    // the modulo-NREQ reduction.
    localparam int XW  = IW + 1;
    localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [XW-1:0]  NREQ_X  = XW'(NREQ);
    localparam logic [WCW-1:0] WC_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [IW-1:0]      cur_q,    cur_d;
    logic [IW-1:0]      last_q,   last_d;
    logic               locked_q, locked_d;
    logic [WCW-1:0]     wcnt_q,   wcnt_d;
    logic [AW-1:0]      addr_q,   addr_d;
    logic [DW-1:0]      dout_q,   dout_d;
    logic               wr_q,     wr_d;

    logic [NREQ-1:0]    cur_oh_s;
    logic [NREQ-1:0]    elig_s;
    logic               any_elig_s;
    logic [IW-1:0]      win_s;
    logic [XW-1:0]      rr_sum_s;
    logic [XW-1:0]      rr_idx_s;
    logic               timeout_s;
    logic [NREQ-1:0]    rdy_s;
    logic [NREQ-1:0]    err_s;

    // One-hot of the current owner and the eligible request set (lock narrows
    // eligibility to the owner only).
    always_comb begin
        cur_oh_s   = {{(NREQ-1){1'b0}}, 1'b1} << cur_q;
        elig_s     = locked_q ? (req_a & cur_oh_s) : req_a;
        any_elig_s = |elig_s;
        timeout_s  = (TIMEOUT > 0) && (wcnt_q == WC_LAST);
    end

    // Winner selection. Both loops run from the least to the most preferred
    // candidate so the most preferred eligible one is written last.
    always_comb begin
        win_s    = '0;
        rr_sum_s = '0;
        rr_idx_s = '0;
        if (PRIO != 0) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                win_s = elig_s[i] ? IW'(i) : win_s;
            end
        end else begin
            for (int k = NREQ; k >= 1; k--) begin
                rr_sum_s = {1'b0, last_q} + XW'(k);
                rr_idx_s = (rr_sum_s >= NREQ_X) ? (rr_sum_s - NREQ_X) : rr_sum_s;
                win_s    = elig_s[rr_idx_s[IW-1:0]] ? rr_idx_s[IW-1:0] : win_s;
            end
        end
    end

    // Next-state, capture and completion/abort strobes.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        locked_d = locked_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        wr_d     = wr_q;
        rdy_s    = '0;
        err_s    = '0;
        case (state_q)
            S_IDLE: begin
                if (locked_q && !req_a[cur_q]) begin
                    // Owner walked away while holding the lock: release it and
                    // arbitrate normally from the next cycle.
                    locked_d = 1'b0;
                end else if (any_elig_s) begin
                    state_d = S_BUSY;
                    cur_d   = win_s;
                    wcnt_d  = '0;
                    addr_d  = addr_a[int'(win_s)*AW +: AW];
                    dout_d  = dout_a[int'(win_s)*DW +: DW];
                    wr_d    = wr_a[win_s];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (rdy_m) begin
                    // Memory completion beats a coincident timeout.
                    rdy_s    = cur_oh_s;
                    last_d   = cur_q;
                    locked_d = lock_a[cur_q];
                    state_d  = S_IDLE;
                end else if (timeout_s) begin
                    rdy_s    = cur_oh_s;
                    err_s    = cur_oh_s;
                    last_d   = cur_q;
                    locked_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    // Saturate so a disabled watchdog never wraps.
                    wcnt_d = (&wcnt_q) ? wcnt_q : (wcnt_q + WCW'(1));
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            last_q   <= IW'(NREQ - 1);
            locked_q <= 1'b0;
            wcnt_q   <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            locked_q <= locked_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            wr_q     <= wr_d;
        end
    end

    // A transaction interrupted by reset ends without any strobe.
    assign rdy_a    = rdy_s & {NREQ{~reset}};
    assign err_a    = err_s & {NREQ{~reset}};
    assign din_a    = {NREQ{din_m}};
    assign addr_m   = addr_q;
    assign dout_m   = dout_q;
    assign wr_m     = wr_q;
    assign req_m    = (state_q == S_BUSY);
    assign busy     = (state_q == S_BUSY);
    assign grant_id = cur_q;

endmodule

// File: doc/mem_arb_rr.md
# mem_arb_rr

Parametrised N-way memory-port arbiter. It sits between NREQ requester ports (cores, DMA) and one shared memory port. Each transaction is granted round-robin or fixed-priority, and the winner's address, write data and write flag are captured into registers so the memory side sees stable values. It adds three things the 4-way arbiter lacks: a lock for atomic back-to-back sequences, a watchdog timeout with an error pulse, and a grant/busy status output.

## Interface
- NREQ, 4: number of requesters, 2..16
- AW, 64: address width
- DW, 64: data width
- PRIO, 0: 0 = round-robin, 1 = fixed priority (lowest index wins)
- TIMEOUT, 256: cycles in BUSY before abort; 0 disables the watchdog
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- addr_a  in  NREQ*AW  requester addresses; slice i = [i*AW +: AW]
- dout_a  in  NREQ*DW  requester write data
- din_a  out  NREQ*DW  read data; din_m broadcast to every slice
- req_a  in  NREQ  request, held by the requester until its rdy_a
- wr_a  in  NREQ  1 = write, 0 = read
- lock_a  in  NREQ  keep the grant for the next transaction of this requester
- rdy_a  out  NREQ  one-cycle completion strobe, one-hot
- err_a  out  NREQ  one-cycle timeout strobe, coincident with rdy_a
- addr_m  out  AW  registered memory address
- dout_m  out  DW  registered write data
- din_m  in  DW  memory read data, valid while rdy_m is high
- req_m  out  1  memory request
- wr_m  out  1  memory write
- rdy_m  in  1  memory completion
- busy  out  1  high in BUSY
- grant_id  out  $clog2(NREQ)  current or last granted requester

## Operation
- State machine has two states: IDLE and BUSY.
- **IDLE**
  - req_m = 0 and rdy_m is ignored.
  - If any eligible req_a bit is set, the winner is chosen combinationally. On that edge: cur <= winner, the addr/dout/wr slices are captured, wcnt <= 0, and the state goes to BUSY.
- **Winner selection**
  - PRIO = 0: first set bit scanning last+1, last+2, … with modulo-NREQ wrap-around.
  - PRIO = 1: lowest-index set bit.
- **Eligibility**
  - When locked = 1, only req_a[cur] is eligible.
  - When locked = 1 and req_a[cur] = 0 in IDLE, locked <= 0; arbitration resumes the next cycle.
- **BUSY**
  - req_m = 1; addr_m, dout_m and wr_m come from the capture registers and are stable for the whole transaction.
  - req_a, addr_a, wr_a and dout_a changes in BUSY are ignored.
- **Completion (rdy_m = 1 in BUSY)**
  - Combinationally, rdy_a[cur] = 1 and every other rdy_a bit is 0.
  - On the edge: last <= cur, locked <= lock_a[cur], state <= IDLE.
- **Watchdog** (TIMEOUT > 0)
  - wcnt increments every BUSY cycle.
  - If wcnt == TIMEOUT-1 and rdy_m = 0: rdy_a[cur] = err_a[cur] = 1 for that cycle. On the edge: last <= cur, locked <= 0, state <= IDLE. The transaction is dropped.
  - If rdy_m and the timeout fall in the same cycle, rdy_m wins and err_a stays 0.
- din_a is always din_m on every slice; requesters qualify it with rdy_a.
- grant_id = cur; busy = (state == BUSY).
- Width rules:
  - NREQ must not exceed 2^$clog2(NREQ); index arithmetic is done in $clog2(NREQ)+1 bits, then reduced modulo NREQ.
  - wcnt is $clog2(TIMEOUT+1) bits and never wraps.

## Timing
- **Reset values:**
  - state IDLE, cur 0, last NREQ-1 (so the first round-robin grant goes to 0), locked 0, wcnt 0.
  - Outputs: req_m 0, wr_m 0, addr_m 0, dout_m 0, rdy_a 0, err_a 0, busy 0, grant_id 0.
- **Reset mid-transaction:** the transaction is abandoned with no rdy_a. The memory side must tolerate req_m dropping.
- **Latency:** req_a rises before edge t, giving req_m = 1 after edge t. A zero-wait memory (rdy_m in the first BUSY cycle) gives rdy_a during cycle t+1.
- **Throughput:** at least one IDLE cycle between transactions, so at most one transaction per 2 cycles.
- **Requester rule:** deassert req_a or present the next request after seeing rdy_a. A req still high in the following IDLE cycle is a new request.
- Simultaneous requests are resolved in one cycle; no request waits more than NREQ-1 grants in round-robin mode when none holds lock.

## Test plan
- Round-robin: NREQ=4, reset, req_a=4'b1111 held and re-raised, rdy_m one cycle after req_m -> grant order 0,1,2,3,0; each rdy_a one-hot; req_m first high 1 cycle after reset release + request.
- Capture: grant 2 with addr 0x100, wr 1, dout 0xAA; change addr_a[2] to 0x200 mid-BUSY with rdy_m delayed 5 cycles -> addr_m stays 0x100, dout_m 0xAA, wr_m 1 throughout.
- Lock: requester 1 lock_a=1 for 3 transactions while req_a[3] high -> grants 1,1,1 then 3; drop req_a[1] with lock high -> lock released, 3 granted.
- Fixed priority: PRIO=1, req_a=4'b1010 repeated -> requester 1 always wins; 3 granted only when req_a[1]=0.
- Watchdog: TIMEOUT=8, rdy_m never asserted -> rdy_a[cur] and err_a[cur] high in the 8th BUSY cycle, req_m 0 next cycle. Also rdy_m arriving in that same 8th cycle -> err_a stays 0.
- Reset mid-BUSY: assert reset in the 3rd BUSY cycle -> next cycle req_m=0, busy=0, no rdy_a; the next round-robin grant goes to 0.
